conv_tile_scheduler: RTL and testbench
======================================

Name: conv_tile_scheduler

Overview:
- Top-level sequencer for one convolution layer on the SYSTOLIC_SIZE x SYSTOLIC_SIZE systolic array.
- Walks every filter group (SYSTOLIC_SIZE filters per group) and, within each group, every output tile (one OFM row segment of up to SYSTOLIC_SIZE columns).
- For each tile it runs weight-load, IFM-load, compute and OFM write-back through start/done handshakes with those units.
- It also publishes the current tile coordinates to the address generators.

Parameters:
- SYSTOLIC_SIZE, 16, array dimension; filters per group and max columns per tile.
- IFM_SIZE, 15, input feature map height/width.
- KERNEL_SIZE, 3, convolution kernel size; derived OFM_SIZE_CONV = IFM_SIZE-KERNEL_SIZE+1.
- NO_FILTER, 512, filter count; must be a multiple of SYSTOLIC_SIZE; derived NO_FG = NO_FILTER/SYSTOLIC_SIZE.
- Derived: NO_TILING_PER_LINE = ceil(OFM_SIZE_CONV/SYSTOLIC_SIZE); NO_TILING = NO_TILING_PER_LINE*OFM_SIZE_CONV.

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  layer start request; sampled only in IDLE.
- wgt_start  out  1  one-cycle pulse: load weights for current filter group.
- wgt_done  in  1  one-cycle pulse from weight loader.
- ifm_start  out  1  one-cycle pulse: load IFM window for current tile.
- ifm_done  in  1  one-cycle pulse from IFM loader.
- cmp_start  out  1  one-cycle pulse: run array for current tile.
- cmp_done  in  1  one-cycle pulse from compute/drain logic.
- wb_start  out  1  one-cycle pulse: write tile results to OFM RAM.
- wb_done  in  1  one-cycle pulse from write-back unit.
- count_filter  out  16  current filter group index, 0..NO_FG-1.
- count_tiling  out  16  current tile index, 0..NO_TILING-1.
- tile_row  out  16  OFM row of current tile.
- tile_col_base  out  16  first OFM column of tile (tile_col*SYSTOLIC_SIZE).
- valid_cols  out  6  valid columns in tile: min(SYSTOLIC_SIZE, OFM_SIZE_CONV - tile_col_base).
- busy  out  1  high from leaving IDLE until return to IDLE.
- done  out  1  one-cycle pulse when the whole layer is written.

Behaviour:
- Reset values: all outputs 0; state IDLE. Reset asserted mid-operation aborts immediately to IDLE; no further pulses are issued.
- States:
  - IDLE: on start=1, clear counters and go to LOAD_WGT.
  - LOAD_WGT: wgt_start pulses on the first cycle in state; wait for wgt_done, then go to LOAD_IFM.
  - LOAD_IFM: ifm_start pulse; on ifm_done go to COMPUTE.
  - COMPUTE: cmp_start pulse; on cmp_done go to WRITE.
  - WRITE: wb_start pulse; on wb_done go to NEXT.
  - NEXT (1 cycle):
    - If count_tiling < NO_TILING-1: increment tile and go to LOAD_IFM.
    - Else if count_filter < NO_FG-1: increment filter, clear tile, go to LOAD_WGT.
    - Else go to FINISH.
  - FINISH (1 cycle): done=1, then IDLE.
- Latency:
  - start sampled at edge t gives wgt_start high in cycle t+1.
  - A *_done sampled at edge t gives the next phase's start pulse in cycle t+1, or cycle t+2 when passing through NEXT.
- Weights load once per filter group. The IFM loads once per tile.
- Tile coordinates:
  - tile_col increments 0..NO_TILING_PER_LINE-1, then wraps to 0 and tile_row increments.
  - tile_col_base and valid_cols are registered and update together with count_tiling in NO_TILING.
  - They are stable for the whole tile.
- Every *_start pulse is exactly one cycle; it is never re-asserted while waiting.
- A *_done received in any state other than its own phase is ignored. A *_done in the same cycle as that phase's start pulse is accepted.
- start while busy is ignored. A new start in the cycle after done begins a fresh layer.
- busy=1 in every state except IDLE, including FINISH.

Test Plan:
1. Defaults (IFM 15, K 3, 512 filters), units ack after 3 cycles:
   - Exactly 32 wgt_start and 32*13=416 each of ifm/cmp/wb pulses.
   - valid_cols=13 always.
   - Single done pulse.
2. IFM_SIZE=20, NO_FILTER=32:
   - OFM 18, 2 tiles/line, 36 tiles, 2 groups.
   - Tile sequence has tile_col_base 0,16 with valid_cols 16,2.
   - count_tiling wraps 35->0 while count_filter goes 0->1.
   - Totals: 2 wgt_start, 72 cmp_start.
3. Zero-latency acks (done asserted in the start cycle):
   - Per tile: ifm_start, cmp_start, wb_start on consecutive cycles, then NEXT.
   - No phase skipped.
4. Spurious handshakes:
   - cmp_done/wb_done pulsed during LOAD_IFM are ignored; FSM waits for ifm_done.
   - start pulsed mid-layer changes nothing.
5. rst asserted during COMPUTE of tile 5, group 1:
   - All outputs 0 and busy=0 asynchronously.
   - A later start restarts at count_filter=0, count_tiling=0 with wgt_start.
6. start in the cycle after done: second full layer runs with identical pulse counts.

Source files
------------

// File: rtl/conv_tile_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : conv_tile_scheduler
// Description : Top-level sequencer for one convolution layer on a
//               SYSTOLIC_SIZE x SYSTOLIC_SIZE systolic array. It walks every
//               filter group and, inside each group, every output tile. Each
//               tile is one OFM row segment of up to SYSTOLIC_SIZE columns.
//               For each tile it drives the weight-load, IFM-load, compute
//               and write-back units through start/done handshakes. It also
//               publishes the current tile coordinates to the address
//               generators.
// Ports       : clk, rst           - clock, asynchronous active-high reset
//               start              - layer start request (sampled in IDLE)
//               wgt/ifm/cmp/wb_start - one-cycle phase start pulses
//               wgt/ifm/cmp/wb_done  - one-cycle phase completion pulses
//               count_filter       - current filter group index
//               count_tiling       - current tile index within the group
//               tile_row           - OFM row of the current tile
//               tile_col_base      - first OFM column of the current tile
//               valid_cols         - number of valid columns in the tile
//               busy, done         - layer activity / completion pulse
// Revision    : 1.0 - initial release
// ============================================================================
module conv_tile_scheduler #(
    parameter int SYSTOLIC_SIZE = 16,
    parameter int IFM_SIZE      = 15,
    parameter int KERNEL_SIZE   = 3,
    parameter int NO_FILTER     = 512
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    output logic        wgt_start,
    input  logic        wgt_done,
    output logic        ifm_start,
    input  logic        ifm_done,
    output logic        cmp_start,
    input  logic        cmp_done,
    output logic        wb_start,
    input  logic        wb_done,
    output logic [15:0] count_filter,
    output logic [15:0] count_tiling,
    output logic [15:0] tile_row,
    output logic [15:0] tile_col_base,
    output logic [5:0]  valid_cols,
    output logic        busy,
    output logic        done
);

    localparam int c_OFM_SIZE_CONV      = IFM_SIZE - KERNEL_SIZE + 1;
    localparam int c_NO_FG              = NO_FILTER / SYSTOLIC_SIZE;
    localparam int c_NO_TILING_PER_LINE = (c_OFM_SIZE_CONV + SYSTOLIC_SIZE - 1) / SYSTOLIC_SIZE;
    localparam int c_NO_TILING          = c_NO_TILING_PER_LINE * c_OFM_SIZE_CONV;

    localparam logic [15:0] c_LAST_TILE = 16'(c_NO_TILING - 1);
    localparam logic [15:0] c_LAST_FG   = 16'(c_NO_FG - 1);
    localparam logic [15:0] c_LAST_COL  = 16'(c_NO_TILING_PER_LINE - 1);
    localparam logic [15:0] c_TILE_W    = 16'(SYSTOLIC_SIZE);
    localparam logic [15:0] c_OFM_W     = 16'(c_OFM_SIZE_CONV);
    localparam logic [5:0]  c_TILE_W6   = 6'(SYSTOLIC_SIZE);
    // Valid width of the first tile on a line (column base 0).
    localparam logic [5:0]  c_FIRST_VALID =
        6'((c_OFM_SIZE_CONV < SYSTOLIC_SIZE) ? c_OFM_SIZE_CONV : SYSTOLIC_SIZE);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_LOAD_WGT = 3'd1,
        S_LOAD_IFM = 3'd2,
        S_COMPUTE  = 3'd3,
        S_WRITE    = 3'd4,
        S_NEXT     = 3'd5,
        S_FINISH   = 3'd6
    } state_t;

    state_t      r_state;
    logic [15:0] r_tile_col;

    // Coordinates of the tile that follows the current one in raster order.
    logic        w_col_wrap;
    logic [15:0] w_next_col;
    logic [15:0] w_next_row;
    logic [15:0] w_next_base;
    logic [15:0] w_rem_cols;
    logic [5:0]  w_next_valid;

    always_comb begin
        w_col_wrap   = (r_tile_col == c_LAST_COL);
        w_next_col   = w_col_wrap ? 16'd0 : r_tile_col + 16'd1;
        w_next_row   = w_col_wrap ? tile_row + 16'd1 : tile_row;
        w_next_base  = w_col_wrap ? 16'd0 : tile_col_base + c_TILE_W;
        // The next base always lies inside the OFM line, so this cannot underflow.
        w_rem_cols   = c_OFM_W - w_next_base;
        w_next_valid = (w_rem_cols > c_TILE_W) ? c_TILE_W6 : w_rem_cols[5:0];
    end

    // Every output is registered. Start pulses are raised on the transition
    // into their phase, so each one lasts exactly the first cycle of that
    // phase. The default assignments below drop them again on the next edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state       <= S_IDLE;
            r_tile_col    <= 16'd0;
            wgt_start     <= 1'b0;
            ifm_start     <= 1'b0;
            cmp_start     <= 1'b0;
            wb_start      <= 1'b0;
            count_filter  <= 16'd0;
            count_tiling  <= 16'd0;
            tile_row      <= 16'd0;
            tile_col_base <= 16'd0;
            valid_cols    <= 6'd0;
            busy          <= 1'b0;
            done          <= 1'b0;
        end else begin
            wgt_start <= 1'b0;
            ifm_start <= 1'b0;
            cmp_start <= 1'b0;
            wb_start  <= 1'b0;
            done      <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_state       <= S_LOAD_WGT;
                        wgt_start     <= 1'b1;
                        busy          <= 1'b1;
                        count_filter  <= 16'd0;
                        count_tiling  <= 16'd0;
                        tile_row      <= 16'd0;
                        r_tile_col    <= 16'd0;
                        tile_col_base <= 16'd0;
                        valid_cols    <= c_FIRST_VALID;
                    end
                end
                S_LOAD_WGT: begin
                    if (wgt_done) begin
                        r_state   <= S_LOAD_IFM;
                        ifm_start <= 1'b1;
                    end
                end
                S_LOAD_IFM: begin
                    if (ifm_done) begin
                        r_state   <= S_COMPUTE;
                        cmp_start <= 1'b1;
                    end
                end
                S_COMPUTE: begin
                    if (cmp_done) begin
                        r_state  <= S_WRITE;
                        wb_start <= 1'b1;
                    end
                end
                S_WRITE: begin
                    if (wb_done) begin
                        r_state <= S_NEXT;
                    end
                end
                S_NEXT: begin
                    if (count_tiling < c_LAST_TILE) begin
                        // Next tile of the same filter group; weights stay loaded.
                        r_state       <= S_LOAD_IFM;
                        ifm_start     <= 1'b1;
                        count_tiling  <= count_tiling + 16'd1;
                        r_tile_col    <= w_next_col;
                        tile_row      <= w_next_row;
                        tile_col_base <= w_next_base;
                        valid_cols    <= w_next_valid;
                    end else if (count_filter < c_LAST_FG) begin
                        // Next filter group restarts the tile walk at the origin.
                        r_state       <= S_LOAD_WGT;
                        wgt_start     <= 1'b1;
                        count_filter  <= count_filter + 16'd1;
                        count_tiling  <= 16'd0;
                        r_tile_col    <= 16'd0;
                        tile_row      <= 16'd0;
                        tile_col_base <= 16'd0;
                        valid_cols    <= c_FIRST_VALID;
                    end else begin
                        r_state <= S_FINISH;
                        done    <= 1'b1;
                    end
                end
                S_FINISH: begin
                    r_state <= S_IDLE;
                    busy    <= 1'b0;
                end
                default: begin
                    r_state <= S_IDLE;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_conv_tile_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : tb_conv_tile_scheduler
// Description : Self-checking bench for conv_tile_scheduler. The DUT uses an
//               18x18 OFM, which gives two tiles per line of width 16 and 2.
//               It has 36 tiles and 2 filter groups. Handshake units are
//               emulated with randomized or zero latency. Observed pulses are
//               compared against a reference event list built from plain
//               loops over groups and tiles.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_conv_tile_scheduler;

    localparam int S    = 16;
    localparam int IFM  = 20;
    localparam int K    = 3;
    localparam int NF   = 32;
    localparam int OFM  = IFM - K + 1;
    localparam int NTPL = (OFM + S - 1) / S;
    localparam int NT   = NTPL * OFM;
    localparam int NFG  = NF / S;

    localparam logic [2:0] EV_W = 3'd0;
    localparam logic [2:0] EV_I = 3'd1;
    localparam logic [2:0] EV_C = 3'd2;
    localparam logic [2:0] EV_B = 3'd3;
    localparam logic [2:0] EV_D = 3'd4;

    logic        clk   = 1'b0;
    logic        rst   = 1'b1;
    logic        start = 1'b0;
    logic        wgt_start, ifm_start, cmp_start, wb_start;
    logic        wgt_done, ifm_done, cmp_done, wb_done;
    logic [15:0] count_filter, count_tiling, tile_row, tile_col_base;
    logic [5:0]  valid_cols;
    logic        busy, done;

    typedef struct packed {
        logic [2:0]  kind;
        logic [15:0] cf;
        logic [15:0] ct;
        logic [15:0] row;
        logic [15:0] base;
        logic [5:0]  valid;
    } ev_t;

    ev_t  log_q[$];
    int   log_cyc[$];
    ev_t  exp_q[$];

    int   checks     = 0;
    int   passed     = 0;
    int   cyc        = 0;
    int   done_cnt   = 0;
    int   long_pulse = 0;
    int   zero_lat   = 0;
    int   lat_min    = 1;
    int   lat_max    = 4;
    logic [3:0] rsp_done = 4'b0;
    logic [3:0] inj_done = 4'b0;
    logic [3:0] prev_st  = 4'b0;
    int   rsp_cnt[4];

    always #5 clk = ~clk;

    assign wgt_done = rsp_done[0] | inj_done[0] | ((zero_lat != 0) & wgt_start);
    assign ifm_done = rsp_done[1] | inj_done[1] | ((zero_lat != 0) & ifm_start);
    assign cmp_done = rsp_done[2] | inj_done[2] | ((zero_lat != 0) & cmp_start);
    assign wb_done  = rsp_done[3] | inj_done[3] | ((zero_lat != 0) & wb_start);

    conv_tile_scheduler #(
        .SYSTOLIC_SIZE (S),
        .IFM_SIZE      (IFM),
        .KERNEL_SIZE   (K),
        .NO_FILTER     (NF)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .start         (start),
        .wgt_start     (wgt_start),
        .wgt_done      (wgt_done),
        .ifm_start     (ifm_start),
        .ifm_done      (ifm_done),
        .cmp_start     (cmp_start),
        .cmp_done      (cmp_done),
        .wb_start      (wb_start),
        .wb_done       (wb_done),
        .count_filter  (count_filter),
        .count_tiling  (count_tiling),
        .tile_row      (tile_row),
        .tile_col_base (tile_col_base),
        .valid_cols    (valid_cols),
        .busy          (busy),
        .done          (done)
    );

    // Emulated load/compute/write-back units: a done pulse follows a start
    // pulse after a random number of cycles.
    initial begin
        for (int i = 0; i < 4; i++) rsp_cnt[i] = 0;
        forever begin
            logic [3:0] st;
            @(negedge clk);
            rsp_done = 4'b0;
            st = {wb_start, cmp_start, ifm_start, wgt_start};
            if (rst) begin
                for (int i = 0; i < 4; i++) rsp_cnt[i] = 0;
            end else begin
                for (int i = 0; i < 4; i++) begin
                    if (rsp_cnt[i] > 0) begin
                        rsp_cnt[i] = rsp_cnt[i] - 1;
                        if (rsp_cnt[i] == 0) rsp_done[i] = 1'b1;
                    end
                end
                if (zero_lat == 0) begin
                    for (int i = 0; i < 4; i++)
                        if (st[i]) rsp_cnt[i] = int'($urandom_range(lat_max, lat_min));
                end
            end
        end
    end

    // Records every start pulse and done pulse, together with the published
    // coordinates.
    initial begin
        forever begin
            logic [3:0] st;
            @(negedge clk);
            cyc = cyc + 1;
            st = {wb_start, cmp_start, ifm_start, wgt_start};
            if ((st & prev_st) != 4'b0) long_pulse = long_pulse + 1;
            prev_st = st;
            for (int i = 0; i < 4; i++) begin
                if (st[i]) begin
                    log_q.push_back('{kind: 3'(i), cf: count_filter, ct: count_tiling,
                                      row: tile_row, base: tile_col_base, valid: valid_cols});
                    log_cyc.push_back(cyc);
                end
            end
            if (done) begin
                log_q.push_back('{kind: EV_D, cf: count_filter, ct: count_tiling,
                                  row: tile_row, base: tile_col_base, valid: valid_cols});
                log_cyc.push_back(cyc);
                done_cnt = done_cnt + 1;
            end
        end
    end

    // Reference event for a phase of filter group fg, tile t.
    function automatic ev_t mk(input logic [2:0] kind, input int fg, input int t);
        int col, base, rem;
        ev_t e;
        col  = t % NTPL;
        base = col * S;
        rem  = OFM - base;
        e.kind  = kind;
        e.cf    = 16'(fg);
        e.ct    = 16'(t);
        e.row   = 16'(t / NTPL);
        e.base  = 16'(base);
        e.valid = 6'((rem < S) ? rem : S);
        return e;
    endfunction

    function automatic void build_model();
        exp_q.delete();
        for (int fg = 0; fg < NFG; fg++) begin
            exp_q.push_back(mk(EV_W, fg, 0));
            for (int t = 0; t < NT; t++) begin
                exp_q.push_back(mk(EV_I, fg, t));
                exp_q.push_back(mk(EV_C, fg, t));
                exp_q.push_back(mk(EV_B, fg, t));
            end
        end
        exp_q.push_back(mk(EV_D, NFG - 1, NT - 1));
    endfunction

    function automatic int count_kind(input logic [2:0] kind);
        int n = 0;
        foreach (log_q[i]) if (log_q[i].kind == kind) n++;
        return n;
    endfunction

    function automatic void clear_log();
        log_q.delete();
        log_cyc.delete();
    endfunction

    // Compares the recorded log against nrep back-to-back copies of the model.
    task automatic compare_log(input string name, input int nrep);
        int n;
        checks++;
        if (log_q.size() != nrep * exp_q.size())
            $display("FAIL %s event count: got %0d required %0d", name, log_q.size(), nrep * exp_q.size());
        else passed++;
        n = (log_q.size() < nrep * exp_q.size()) ? log_q.size() : nrep * exp_q.size();
        for (int i = 0; i < n; i++) begin
            checks++;
            if (log_q[i] !== exp_q[i % exp_q.size()])
                $display("FAIL %s event %0d: got kind=%0d cf=%0d ct=%0d row=%0d base=%0d valid=%0d required kind=%0d cf=%0d ct=%0d row=%0d base=%0d valid=%0d",
                         name, i, log_q[i].kind, log_q[i].cf, log_q[i].ct, log_q[i].row, log_q[i].base, log_q[i].valid,
                         exp_q[i % exp_q.size()].kind, exp_q[i % exp_q.size()].cf, exp_q[i % exp_q.size()].ct,
                         exp_q[i % exp_q.size()].row, exp_q[i % exp_q.size()].base, exp_q[i % exp_q.size()].valid);
            else passed++;
        end
    endtask

    task automatic pulse_start();
        @(negedge clk); #1;
        start = 1'b1;
        @(negedge clk); #1;
        start = 1'b0;
    endtask

    task automatic wait_done(input int base_cnt, input int budget, input string name);
        int n = 0;
        while (done_cnt == base_cnt && n < budget) begin
            @(negedge clk); #1;
            n++;
        end
        checks++;
        if (done_cnt == base_cnt)
            $display("FAIL %s timeout: done not seen within %0d cycles, required one done pulse", name, budget);
        else passed++;
    endtask

    // One full layer with start latency and busy/done framing checks.
    task automatic run_layer(input string name);
        int b;
        clear_log();
        b = done_cnt;
        pulse_start();
        checks++;
        if ({wgt_start, busy} !== 2'b11)
            $display("FAIL %s start latency: wgt_start,busy got %b required 11", name, {wgt_start, busy});
        else passed++;
        wait_done(b, 20000, name);
        checks++;
        if ({busy, done} !== 2'b11)
            $display("FAIL %s finish cycle: busy,done got %b required 11", name, {busy, done});
        else passed++;
        @(negedge clk); #1;
        checks++;
        if ({busy, done} !== 2'b00)
            $display("FAIL %s idle after done: busy,done got %b required 00", name, {busy, done});
        else passed++;
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        #1;
        checks++;
        if ({wgt_start, ifm_start, cmp_start, wb_start, busy, done} !== 6'b0)
            $display("FAIL reset flags: got %b required 000000",
                     {wgt_start, ifm_start, cmp_start, wb_start, busy, done});
        else passed++;
        checks++;
        if ({count_filter, count_tiling, tile_row, tile_col_base, valid_cols} !== 70'b0)
            $display("FAIL reset coords: got cf=%0d ct=%0d row=%0d base=%0d valid=%0d required all 0",
                     count_filter, count_tiling, tile_row, tile_col_base, valid_cols);
        else passed++;
        rst = 1'b0;
    endtask

    task automatic test_full_layer();
        zero_lat = 0; lat_min = 1; lat_max = 4;
        build_model();
        run_layer("full_layer");
        compare_log("full_layer", 1);
        checks++;
        if (count_kind(EV_W) != NFG)
            $display("FAIL wgt_start total: got %0d required %0d", count_kind(EV_W), NFG);
        else passed++;
        checks++;
        if (count_kind(EV_C) != NFG * NT)
            $display("FAIL cmp_start total: got %0d required %0d", count_kind(EV_C), NFG * NT);
        else passed++;
        checks++;
        if (count_kind(EV_D) != 1)
            $display("FAIL done total: got %0d required 1", count_kind(EV_D));
        else passed++;
    endtask

    task automatic test_zero_latency();
        int bad = 0;
        int gap;
        zero_lat = 1;
        build_model();
        run_layer("zero_latency");
        compare_log("zero_latency", 1);
        for (int i = 1; i < log_q.size(); i++) begin
            gap = (log_q[i-1].kind == EV_B) ? 2 : 1;
            if (log_cyc[i] - log_cyc[i-1] != gap) bad++;
        end
        checks++;
        if (bad != 0)
            $display("FAIL zero_latency spacing: got %0d bad gaps required 0", bad);
        else passed++;
        zero_lat = 0;
    endtask

    task automatic test_spurious();
        int b;
        int n = 0;
        zero_lat = 0; lat_min = 4; lat_max = 4;
        build_model();
        clear_log();
        b = done_cnt;
        pulse_start();
        while (count_kind(EV_I) < 3 && n < 5000) begin
            @(negedge clk); #1;
            n++;
        end
        checks++;
        if (count_kind(EV_I) < 3)
            $display("FAIL spurious wait: got %0d ifm_start required 3", count_kind(EV_I));
        else passed++;
        // Still in LOAD_IFM: fire out-of-phase dones and a stray start.
        @(negedge clk); #1;
        inj_done = 4'b1100;
        start    = 1'b1;
        @(negedge clk); #1;
        inj_done = 4'b0000;
        start    = 1'b0;
        checks++;
        if ({cmp_start, wb_start, wgt_start, busy} !== 4'b0001)
            $display("FAIL spurious ignored: cmp,wb,wgt,busy got %b required 0001",
                     {cmp_start, wb_start, wgt_start, busy});
        else passed++;
        wait_done(b, 20000, "spurious");
        compare_log("spurious", 1);
        @(negedge clk); #1;
        lat_min = 1;
    endtask

    task automatic test_reset_mid();
        int n = 0;
        int sz;
        zero_lat = 0; lat_min = 1; lat_max = 4;
        clear_log();
        pulse_start();
        while (!(log_q.size() > 0 && log_q[$].kind == EV_C && log_q[$].cf == 16'd1 &&
                 log_q[$].ct == 16'd5) && n < 20000) begin
            @(negedge clk); #1;
            n++;
        end
        checks++;
        if (n >= 20000)
            $display("FAIL reset_mid wait: got no cmp_start at group 1 tile 5, required one");
        else passed++;
        rst = 1'b1;
        #1;
        checks++;
        if ({wgt_start, ifm_start, cmp_start, wb_start, busy, done, count_filter, count_tiling,
             tile_row, tile_col_base, valid_cols} !== 76'b0)
            $display("FAIL reset_mid async clear: got busy=%b cmp=%b cf=%0d ct=%0d row=%0d base=%0d valid=%0d required all 0",
                     busy, cmp_start, count_filter, count_tiling, tile_row, tile_col_base, valid_cols);
        else passed++;
        sz = log_q.size();
        repeat (3) @(negedge clk);
        #1;
        rst = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        checks++;
        if (log_q.size() != sz || busy !== 1'b0)
            $display("FAIL reset_mid quiet: got %0d new events busy=%b required 0 events busy=0",
                     log_q.size() - sz, busy);
        else passed++;
        build_model();
        run_layer("reset_restart");
        compare_log("reset_restart", 1);
    endtask

    task automatic test_back_to_back();
        int b;
        int d_idx;
        zero_lat = 0; lat_min = 1; lat_max = 4;
        build_model();
        clear_log();
        b = done_cnt;
        pulse_start();
        wait_done(b, 20000, "b2b_first");
        // Hold start across the FINISH edge and the following IDLE edge.
        start = 1'b1;
        @(negedge clk); #1;
        @(negedge clk); #1;
        start = 1'b0;
        checks++;
        if (wgt_start !== 1'b1)
            $display("FAIL b2b restart: wgt_start got %b required 1 two cycles after done", wgt_start);
        else passed++;
        wait_done(b + 1, 20000, "b2b_second");
        compare_log("back_to_back", 2);
        d_idx = exp_q.size() - 1;
        checks++;
        if (log_q.size() > d_idx + 1 && log_cyc[d_idx + 1] - log_cyc[d_idx] != 2)
            $display("FAIL b2b gap: got %0d cycles done->wgt_start required 2",
                     log_cyc[d_idx + 1] - log_cyc[d_idx]);
        else passed++;
        @(negedge clk); #1;
    endtask

    initial begin
        test_reset();
        test_full_layer();
        test_zero_latency();
        test_spurious();
        test_reset_mid();
        test_back_to_back();
        checks++;
        if (long_pulse != 0)
            $display("FAIL pulse width: got %0d multi-cycle start pulses required 0", long_pulse);
        else passed++;
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
`default_nettype wire
